// File: rtl/sum_bcd_display.sv
// sum_bcd_display
// Sequential binary-to-BCD converter and 7-segment driver for the ripple
// adder's {cout,sum} result. A value accepted through a valid/ready handshake
// is converted with an iterative shift-add-3 (double dabble), one bit per
// clock. The result is then driven onto two active-low DE2 HEX displays.
//
// Ports
//   Clock     in   1          system clock, rising edge
//   Resetn    in   1          asynchronous active-low reset
//   in_valid  in   1          in_data is valid this cycle
//   in_data   in   WIDTH      unsigned binary value
//   in_ready  out  1          converter idle; accepts when in_valid & in_ready
//   done      out  1          one-cycle pulse when bcd_out/HEX update
//   bcd_out   out  4*DIGITS   packed BCD, ones digit in [3:0]
//   HEX0      out  7          ones digit segments, active-low gfedcba
//   HEX1      out  7          tens digit segments, active-low gfedcba
module sum_bcd_display #(
  parameter int WIDTH    = 5,
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            HEX0,
  output logic [6:0]            HEX1
);

  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT               stateQ;
  logic [SW-1:0]       shiftQ;
  logic [CW-1:0]       cntQ;
  logic                readyQ;
  logic                doneQ;
  logic [4*DIGITS-1:0] bcdQ;
  logic [6:0]          hex0Q;
  logic [6:0]          hex1Q;

  logic [SW-1:0]       shiftD;
  logic [SW-1:0]       adjusted;
  logic [4*DIGITS-1:0] bcdD;
  logic [6:0]          segD [DIGITS];
  logic [3:0]          digit;
  logic                higherZero;

  // Active-low gfedcba encoding; non-decimal nibbles are shown blank.
  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    segOf = 7'b1000000;
      4'd1:    segOf = 7'b1111001;
      4'd2:    segOf = 7'b0100100;
      4'd3:    segOf = 7'b0110000;
      4'd4:    segOf = 7'b0011001;
      4'd5:    segOf = 7'b0010010;
      4'd6:    segOf = 7'b0000010;
      4'd7:    segOf = 7'b1111000;
      4'd8:    segOf = 7'b0000000;
      4'd9:    segOf = 7'b0010000;
      default: segOf = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step: correct every BCD nibble >= 5 by +3, then shift
  // the whole register left. bcdD/segD hold what the final step would show,
  // so the last shift edge can register the display directly.
  always_comb begin
    adjusted = shiftQ;
    for (int i = 0; i < DIGITS; i++) begin
      if (shiftQ[WIDTH+4*i +: 4] >= 4'd5) begin
        adjusted[WIDTH+4*i +: 4] = shiftQ[WIDTH+4*i +: 4] + 4'd3;
      end
    end
    shiftD = {adjusted[SW-2:0], 1'b0};
    bcdD   = shiftD[SW-1:WIDTH];

    // Walk from the most significant digit down; a digit is blanked while it
    // and everything above it is zero. The ones digit is always shown.
    higherZero = 1'b1;
    digit      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      segD[i] = 7'b1111111;
    end
    for (int i = DIGITS-1; i >= 0; i--) begin
      digit      = bcdD[4*i +: 4];
      higherZero = higherZero && (digit == 4'd0);
      if ((BLANK_LZ != 0) && higherZero && (i != 0)) begin
        segD[i] = 7'b1111111;
      end else begin
        segD[i] = segOf(digit);
      end
    end
  end

  // Control FSM plus all registered outputs. Reset aborts any conversion in
  // flight and blanks the displays.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stateQ <= IDLE;
      shiftQ <= '0;
      cntQ   <= '0;
      readyQ <= 1'b1;
      doneQ  <= 1'b0;
      bcdQ   <= '0;
      hex0Q  <= 7'b1111111;
      hex1Q  <= 7'b1111111;
    end else begin
      case (stateQ)
        IDLE: begin
          doneQ <= 1'b0;
          if (in_valid && readyQ) begin
            shiftQ <= {{(4*DIGITS){1'b0}}, in_data};
            cntQ   <= CW'(WIDTH);
            readyQ <= 1'b0;
            stateQ <= SHIFT;
          end
        end
        SHIFT: begin
          shiftQ <= shiftD;
          cntQ   <= cntQ - CW'(1);
          if (cntQ == CW'(1)) begin
            bcdQ   <= bcdD;
            hex0Q  <= segD[0];
            hex1Q  <= segD[1];
            doneQ  <= 1'b1;
            stateQ <= DONE;
          end
        end
        DONE: begin
          doneQ  <= 1'b0;
          readyQ <= 1'b1;
          stateQ <= IDLE;
        end
        default: begin
          doneQ  <= 1'b0;
          readyQ <= 1'b1;
          stateQ <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = readyQ;
  assign done     = doneQ;
  assign bcd_out  = bcdQ;
  assign HEX0     = hex0Q;
  assign HEX1     = hex1Q;

endmodule
